// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider for the ALU DIV operation (quotient -> LO, remainder -> HI).
// Optional macro DIV_EARLY_EXIT_EN skips the leading-zero iterations of |dividend|.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state;
  logic             sign_q;
  logic             sign_r;
  logic             dz;
  logic [WIDTH-1:0] mag_dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dq;
  logic [CW-1:0]    n;

  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dq_init;
  logic [CW-1:0]    n_init;

  // |0x80..0| wraps back to 0x80..0, which is the correct unsigned magnitude
  always_comb begin
    abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    abs_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;
  end

  always_comb begin
    p     = {rem[WIDTH-2:0], dq[WIDTH-1]};
    trial = {1'b0, p} - {1'b0, mag_dvs};
  end

`ifdef DIV_EARLY_EXIT_EN
  logic [CW-1:0] clz;
  logic          found;

  always_comb begin
    clz   = CW'(WIDTH);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && abs_dvd[WIDTH-1-i]) begin
        clz   = CW'(i);
        found = 1'b1;
      end
    end
    dq_init = abs_dvd << clz;
    n_init  = CW'(WIDTH) - clz;
  end
`else
  always_comb begin
    dq_init = abs_dvd;
    n_init  = CW'(WIDTH);
  end
`endif

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      mag_dvs     <= '0;
      rem         <= '0;
      dq          <= '0;
      n           <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r  <= dividend[WIDTH-1];
            mag_dvs <= abs_dvs;
            rem     <= '0;
            n       <= n_init;
            busy    <= 1'b1;
            // on divide-by-zero dq keeps the unshifted |dividend| for the remainder output
            if (divisor == '0) begin
              dz    <= 1'b1;
              dq    <= abs_dvd;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              dq    <= dq_init;
              state <= (n_init == '0) ? FIX : ITER;
            end
          end
        end
        ITER: begin
          dq  <= {dq[WIDTH-2:0], ~trial[WIDTH]};
          rem <= trial[WIDTH] ? p : trial[WIDTH-1:0];
          n   <= n - CW'(1);
          if (n == CW'(1))
            state <= FIX;
        end
        FIX: begin
          if (dz) begin
            quotient    <= '0;
            remainder   <= sign_r ? -dq : dq;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= sign_q ? -dq : dq;
            remainder   <= sign_r ? -rem : rem;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against a 64-bit arithmetic reference model.
module tb_seq_divider;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(32)) dut (
    .Clock(Clock), .Clear(Clear), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Cycles from the start edge to the edge that raises done
  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag;
    int bits;
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
    mag  = a[31] ? (32'd0 - a) : a;
    bits = 0;
    while (mag != 32'd0) begin
      bits++;
      mag = mag >> 1;
    end
    return bits + 1;
`else
    return 33;
`endif
  endfunction

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'd0; r = a; z = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Called 1ns after a rising edge. inj>0 pulses start with (ia,ib) before edge E+inj.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input int inj, input logic [31:0] ia, input logic [31:0] ib);
    logic [31:0] eq, er;
    logic        ez;
    int          lat;
    ref_div(a, b, eq, er, ez);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 80; k++) begin
      if (k == inj) begin
        dividend = ia;
        divisor  = ib;
        start    = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, exp_latency(a, b));
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_plain(input logic [31:0] a, input logic [31:0] b);
    run_div(a, b, 0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, hold_q;
    int pulses;

    Clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dz", {31'd0, div_by_zero}, 32'd0);

    // start together with Clear must be ignored
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; Clear = 1'b0;
    tick();
    check("start_with_clear", {31'd0, busy}, 32'd0);

    run_plain(32'h8FFFFFFF, 32'h00000003);
    run_plain(32'h00000027, 32'h00000003);
    run_plain(32'hFFFFFFF9, 32'h00000002);
    run_plain(32'h00000007, 32'hFFFFFFFE);
    run_plain(32'h80000000, 32'hFFFFFFFF);
    run_plain(32'h00000005, 32'h00000000);
    run_plain(32'h00000006, 32'h00000003);
    run_plain(32'h00000000, 32'h00000005);
    run_plain(32'h80000000, 32'h00000000);
    run_plain(32'h7FFFFFFF, 32'h80000000);

    // results hold while idle
    hold_q = quotient;
    tick(); tick(); tick();
    check("hold_quotient", quotient, hold_q);

    // Clear at E+10 aborts the divide; no done pulse may follow
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_plain(32'd100, 32'd7);

    // start during a busy divide is ignored; exactly one done follows
    run_div(32'h00000027, 32'h00000003, 5, 32'd1, 32'd1);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) pulses++;
    end
    check("ignored_start_no_done", pulses, 0);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 4))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 5000) - 2500; b = $urandom_range(1, 40) - 20; end
        2: begin a = $urandom; b = 32'd0; end
        3: begin a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
                 b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom; end
        default: begin a = $urandom >> $urandom_range(0, 31); b = $urandom >> $urandom_range(16, 31); end
      endcase
      run_plain(a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
